search_loader: RTL and testbench
================================

# search_loader

Host-side front end for the DES brute-force key search core. It accepts the known plaintext/ciphertext pair as a 16-byte stream over a valid/ready handshake, holds both words stable for the core, clears and launches the search, and watches the core's match flag. It latches the winning key and count, or reports exhaustion of the 56-bit key space, then sits upstream of the next load.

## Interface
Parameters:
- CNT_W, 56, width of the core's key counter
- KEY_W, 64, width of the parity-expanded key

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- byte_in  in  8  host data byte
- byte_valid  in  1  host byte present
- byte_ready  out  1  loader can accept a byte
- abort  in  1  abandon current load/search
- plaintext  out  64  held plaintext to core
- ciphertext  out  64  held target ciphertext to core
- core_reset  out  1  one-cycle clear pulse to search core
- Start  out  1  launch/enable to search core
- FoundKeyNum  in  1  core match flag
- Key  in  KEY_W  core's current parity-expanded key
- count  in  CNT_W  core's current counter value
- found_key  out  KEY_W  latched matching key
- found_count  out  CNT_W  latched counter at match
- busy  out  1  CLEAR or SEARCH state
- done  out  1  key found, sticky
- fail  out  1  key space exhausted, sticky

## Operation
- States: LOAD, CLEAR, SEARCH, DONE, FAIL. Reset → LOAD.
- Handshake: byte accepted on a clock edge with byte_valid && byte_ready. byte_ready = 1 in LOAD, DONE and FAIL; 0 in CLEAR and SEARCH. byte_valid without ready is ignored; there is no buffering.
- Byte order: bytes 0–7 go to plaintext and bytes 8–15 go to ciphertext, MSB byte first. Byte 0 → plaintext[63:56] and byte 15 → ciphertext[7:0]. Load uses a 4-bit byte index; each byte is written directly into its slot, not shifted.
- LOAD: the 16th accepted byte (index 15) → CLEAR.
- CLEAR: core_reset = 1 for exactly this cycle → SEARCH.
- SEARCH: Start = 1 held for the whole state.
  - FoundKeyNum = 1: latch Key → found_key and count → found_count, then → DONE.
  - Otherwise, count == all-ones (2^CNT_W − 1) → FAIL.
  - Both in the same cycle: the found case wins.
- DONE and FAIL: done or fail is held, and found_key/found_count are held. The first accepted byte starts a new load: it is written as index 0, done and fail clear, and the state → LOAD.
- abort (any state except reset): next state LOAD, byte index 0, Start 0, done/fail 0, core_reset = 1 on the following cycle. plaintext/ciphertext keep their old values.
- reset overrides abort and all other inputs.
- plaintext/ciphertext change only during byte acceptance, so they are stable throughout CLEAR and SEARCH.

## Timing
- Reset values:
  - state LOAD, byte index 0, byte_ready 1
  - Start 0, core_reset 0, busy 0, done 0, fail 0
  - plaintext, ciphertext, found_key, found_count all 0
- Last byte accepted at edge N: CLEAR during cycle N+1 with core_reset = 1; SEARCH from cycle N+2 with Start = 1.
- FoundKeyNum high at edge M: DONE and done = 1 from cycle M+1, Start = 0 from M+1. found_key/found_count equal the Key/count sampled at edge M.
- FoundKeyNum is ignored outside SEARCH, including during CLEAR.
- busy = 1 exactly in CLEAR and SEARCH.
- All outputs are registered or decoded from the state register only; there is no combinational path from an input to an output.

## Test plan
- Reset, then stream bytes 0x00..0x0F with valid held high → plaintext = 64'h0001020304050607, ciphertext = 64'h08090A0B0C0D0E0F. One core_reset pulse follows the 16th accept, Start rises the next cycle, and byte_ready = 0 from then on.
- Gap the valid signal randomly during the load → identical words result; no byte is duplicated or lost. Valid asserted during SEARCH → ignored.
- Core stub raises FoundKeyNum with Key = 64'h0123456789ABCDEF and count = 56'h12345 → done = 1 next cycle, found_key/found_count match, Start drops. Flags stay held until the next byte is accepted.
- Stub drives count = 56'hFF_FFFF_FFFF_FFFF with FoundKeyNum = 0 → fail = 1. The same count with FoundKeyNum = 1 → done = 1 and fail = 0.
- Assert abort at byte 7 and again mid-SEARCH → LOAD, core_reset pulses one cycle later, and a fresh 16-byte load then completes normally.
- Assert reset mid-SEARCH together with abort → all outputs return to their reset values the next cycle and no core_reset pulse is issued.

Source files
------------

// File: rtl/search_loader.sv
// Host front end for the DES key search core: loads the plaintext/ciphertext
// pair byte by byte, launches the core, and captures the match or exhaustion.
module search_loader #(
  parameter int CNT_W = 56,
  parameter int KEY_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             abort,
  output logic [63:0]      plaintext,
  output logic [63:0]      ciphertext,
  output logic             core_reset,
  output logic             Start,
  input  logic             FoundKeyNum,
  input  logic [KEY_W-1:0] Key,
  input  logic [CNT_W-1:0] count,
  output logic [KEY_W-1:0] found_key,
  output logic [CNT_W-1:0] found_count,
  output logic             busy,
  output logic             done,
  output logic             fail
);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_CLEAR,
    ST_SEARCH,
    ST_DONE,
    ST_FAIL
  } state_t;

  state_t     state;
  logic [3:0] idx;
  logic [5:0] lsb;

  // Byte 0 of each word lands in its top byte, so the slot offset is 7 - idx[2:0].
  assign lsb = {~idx[2:0], 3'b000};

  assign byte_ready = (state == ST_LOAD) || (state == ST_DONE) || (state == ST_FAIL);
  assign busy       = (state == ST_CLEAR) || (state == ST_SEARCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_LOAD;
      idx         <= 4'd0;
      plaintext   <= '0;
      ciphertext  <= '0;
      core_reset  <= 1'b0;
      Start       <= 1'b0;
      found_key   <= '0;
      found_count <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      core_reset <= 1'b0;
      if (abort) begin
        state      <= ST_LOAD;
        idx        <= 4'd0;
        Start      <= 1'b0;
        done       <= 1'b0;
        fail       <= 1'b0;
        core_reset <= 1'b1;
      end else begin
        case (state)
          ST_LOAD: begin
            if (byte_valid) begin
              if (idx[3]) ciphertext[lsb +: 8] <= byte_in;
              else        plaintext[lsb +: 8]  <= byte_in;
              idx <= idx + 4'd1;
              if (idx == 4'd15) begin
                state      <= ST_CLEAR;
                core_reset <= 1'b1;
              end
            end
          end
          ST_CLEAR: begin
            state <= ST_SEARCH;
            Start <= 1'b1;
          end
          ST_SEARCH: begin
            // A match in the final counter slot still counts as a find.
            if (FoundKeyNum) begin
              found_key   <= Key;
              found_count <= count;
              done        <= 1'b1;
              Start       <= 1'b0;
              state       <= ST_DONE;
            end else if (count == {CNT_W{1'b1}}) begin
              fail  <= 1'b1;
              Start <= 1'b0;
              state <= ST_FAIL;
            end
          end
          ST_DONE, ST_FAIL: begin
            if (byte_valid) begin
              plaintext[63:56] <= byte_in;
              idx              <= 4'd1;
              done             <= 1'b0;
              fail             <= 1'b0;
              state            <= ST_LOAD;
            end
          end
          default: state <= ST_LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_search_loader.sv
// Randomized scoreboard bench for search_loader: a host driver plus a scripted
// search-core stub, with outcomes predicted from a byte-array model.
module tb_search_loader;

  logic        clk = 1'b0;
  logic        reset, byte_valid, abort, FoundKeyNum;
  logic [7:0]  byte_in;
  logic [63:0] Key;
  logic [55:0] count;
  logic        byte_ready, core_reset, Start, busy, done, fail;
  logic [63:0] plaintext, ciphertext, found_key;
  logic [55:0] found_count;

  typedef struct {
    bit          isFail;
    logic [63:0] key;
    logic [55:0] cnt;
    logic [63:0] pt;
    logic [63:0] ct;
  } expT;

  expT         sb[$];
  expT         mon;
  int          tests = 0;
  int          failures = 0;
  logic [7:0]  cur[16];
  logic [7:0]  loadData[16];
  logic [63:0] lastKey = '0;
  logic [55:0] lastCount = '0;
  logic        prevDone = 1'b0;
  logic        prevFail = 1'b0;

  search_loader #(.CNT_W(56), .KEY_W(64)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .abort(abort), .plaintext(plaintext),
    .ciphertext(ciphertext), .core_reset(core_reset), .Start(Start),
    .FoundKeyNum(FoundKeyNum), .Key(Key), .count(count),
    .found_key(found_key), .found_count(found_count), .busy(busy),
    .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word model: byte i of the stream is the i-th most significant byte.
  function automatic logic [63:0] wordOf(input int base);
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++) w = (w << 8) | 64'(cur[base + i]);
    return w;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [55:0] randNonTerm();
    logic [55:0] c = rand64()[55:0];
    if (&c) c[0] = 1'b0;
    return c;
  endfunction

  // Monitor: every rising done/fail is a DUT result that must match the scoreboard.
  always @(negedge clk) begin
    if ((done && !prevDone) || (fail && !prevFail)) begin
      if (sb.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL sb_unexpected: got done=%0b fail=%0b expected no result", done, fail);
      end else begin
        mon = sb.pop_front();
        checkOutput("sb_done", 64'(done), 64'(!mon.isFail));
        checkOutput("sb_fail", 64'(fail), 64'(mon.isFail));
        checkOutput("sb_found_key", found_key, mon.key);
        checkOutput("sb_found_count", 64'(found_count), 64'(mon.cnt));
        checkOutput("sb_plaintext", plaintext, mon.pt);
        checkOutput("sb_ciphertext", ciphertext, mon.ct);
      end
    end
    prevDone = done;
    prevFail = fail;
  end

  task automatic checkResetValues();
    checkOutput("rst_byte_ready", 64'(byte_ready), 64'd1);
    checkOutput("rst_start", 64'(Start), 64'd0);
    checkOutput("rst_core_reset", 64'(core_reset), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_fail", 64'(fail), 64'd0);
    checkOutput("rst_plaintext", plaintext, 64'd0);
    checkOutput("rst_ciphertext", ciphertext, 64'd0);
    checkOutput("rst_found_key", found_key, 64'd0);
    checkOutput("rst_found_count", 64'(found_count), 64'd0);
  endtask

  task automatic randomLoad();
    for (int i = 0; i < 16; i++) loadData[i] = 8'($urandom);
  endtask

  // Streams the first nBytes of loadData with random valid gaps; a full load
  // also checks the CLEAR pulse and that a match flag during CLEAR is ignored.
  task automatic applyStimulus(input int nBytes, input int gapPct);
    for (int i = 0; i < nBytes; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checkOutput("flags_clear_on_load", 64'({done, fail}), 64'd0);
      end
      while ($urandom_range(99) < gapPct) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_in    = loadData[i];
      checkOutput("load_byte_ready", 64'(byte_ready), 64'd1);
      cur[i] = loadData[i];
      @(posedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (nBytes == 16) begin
      checkOutput("clear_core_reset", 64'(core_reset), 64'd1);
      checkOutput("clear_busy", 64'(busy), 64'd1);
      checkOutput("clear_byte_ready", 64'(byte_ready), 64'd0);
      checkOutput("clear_start", 64'(Start), 64'd0);
      FoundKeyNum = 1'b1;
      Key         = rand64();
      count       = '1;
      @(negedge clk);
      FoundKeyNum = 1'b0;
      count       = '0;
      checkOutput("search_core_reset", 64'(core_reset), 64'd0);
      checkOutput("search_start", 64'(Start), 64'd1);
      checkOutput("search_flags", 64'({done, fail}), 64'd0);
      checkOutput("load_plaintext", plaintext, wordOf(0));
      checkOutput("load_ciphertext", ciphertext, wordOf(8));
    end
  endtask

  // kind 0: match, 1: counter exhausted, 2: match on the last counter value.
  task automatic runSearch(input int kind, input logic [63:0] inKey, input logic [55:0] inCount);
    expT e;
    byte_valid = 1'b1;
    byte_in    = 8'($urandom);
    repeat (2) @(negedge clk);
    byte_valid = 1'b0;
    checkOutput("search_pt_stable", plaintext, wordOf(0));
    checkOutput("search_ct_stable", ciphertext, wordOf(8));
    checkOutput("search_ready_low", 64'(byte_ready), 64'd0);
    repeat ($urandom_range(1, 5)) begin
      FoundKeyNum = 1'b0;
      Key         = rand64();
      count       = randNonTerm();
      @(negedge clk);
      checkOutput("search_start_held", 64'(Start), 64'd1);
    end
    FoundKeyNum = (kind != 1);
    Key         = inKey;
    count       = (kind == 0) ? inCount : '1;
    if (FoundKeyNum) begin
      lastKey   = Key;
      lastCount = count;
    end
    e.isFail = !FoundKeyNum;
    e.key    = lastKey;
    e.cnt    = lastCount;
    e.pt     = wordOf(0);
    e.ct     = wordOf(8);
    sb.push_back(e);
    @(negedge clk);
    FoundKeyNum = 1'b0;
    count       = '0;
    checkOutput("end_done", 64'(done), 64'(kind != 1));
    checkOutput("end_fail", 64'(fail), 64'(kind == 1));
    checkOutput("end_start", 64'(Start), 64'd0);
    checkOutput("end_busy", 64'(busy), 64'd0);
    checkOutput("end_byte_ready", 64'(byte_ready), 64'd1);
    repeat (3) begin
      FoundKeyNum = 1'($urandom);
      Key         = rand64();
      count       = rand64()[55:0];
      @(negedge clk);
      checkOutput("hold_flags", 64'({done, fail}), 64'({kind != 1, kind == 1}));
      checkOutput("hold_found_key", found_key, lastKey);
      checkOutput("hold_found_count", 64'(found_count), 64'(lastCount));
    end
    FoundKeyNum = 1'b0;
    count       = '0;
  endtask

  task automatic abortNow(input string tag);
    abort      = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    checkOutput({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    checkOutput({tag, "_start"}, 64'(Start), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_flags"}, 64'({done, fail}), 64'd0);
    checkOutput({tag, "_plaintext"}, plaintext, wordOf(0));
    checkOutput({tag, "_ciphertext"}, ciphertext, wordOf(8));
    @(negedge clk);
    checkOutput({tag, "_pulse_end"}, 64'(core_reset), 64'd0);
  endtask

  task automatic resetNow();
    reset = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    checkResetValues();
    reset = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 16; i++) cur[i] = 8'd0;
    lastKey   = '0;
    lastCount = '0;
    @(negedge clk);
    checkOutput("post_reset_core_reset", 64'(core_reset), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    abort       = 1'b0;
    byte_valid  = 1'b0;
    byte_in     = 8'd0;
    FoundKeyNum = 1'b0;
    Key         = '0;
    count       = '0;
    for (int i = 0; i < 16; i++) cur[i] = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkResetValues();

    for (int i = 0; i < 16; i++) loadData[i] = 8'(i);
    applyStimulus(16, 0);
    checkOutput("const_plaintext", plaintext, 64'h0001020304050607);
    checkOutput("const_ciphertext", ciphertext, 64'h08090A0B0C0D0E0F);
    runSearch(0, 64'h0123456789ABCDEF, 56'h12345);

    randomLoad();
    applyStimulus(16, 40);
    runSearch(1, rand64(), '0);

    randomLoad();
    applyStimulus(16, 30);
    runSearch(2, rand64(), '0);

    randomLoad();
    applyStimulus(7, 20);
    abortNow("abort_load");
    randomLoad();
    applyStimulus(16, 20);
    runSearch(0, rand64(), randNonTerm());

    randomLoad();
    applyStimulus(16, 10);
    abortNow("abort_search");
    randomLoad();
    applyStimulus(16, 10);
    runSearch(int'($urandom_range(2)), rand64(), randNonTerm());

    randomLoad();
    applyStimulus(16, 10);
    resetNow();
    randomLoad();
    applyStimulus(16, 25);
    runSearch(int'($urandom_range(2)), rand64(), randNonTerm());

    for (int n = 0; n < 6; n++) begin
      randomLoad();
      applyStimulus(16, int'($urandom_range(50)));
      runSearch(int'($urandom_range(2)), rand64(), randNonTerm());
    end

    @(negedge clk);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
